// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state encoding and iterative-unit modes for multicycle_alu.
// The multiplier is only built when MULTICYCLE_ALU_MUL_EN is defined.
package alu_pkg;

    localparam int ALU_WIDTH_DEF = 32;

    localparam logic [31:0] OP_ADD = 32'd1;
    localparam logic [31:0] OP_SUB = 32'd2;
    localparam logic [31:0] OP_AND = 32'd3;
    localparam logic [31:0] OP_OR  = 32'd4;
    localparam logic [31:0] OP_XOR = 32'd5;
    localparam logic [31:0] OP_SGE = 32'd6;
    localparam logic [31:0] OP_SLT = 32'd7;
    localparam logic [31:0] OP_SEQ = 32'd10;
    localparam logic [31:0] OP_SLI = 32'd17;
    localparam logic [31:0] OP_SRI = 32'd18;
    localparam logic [31:0] OP_MUL = 32'd24;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        MUL   = 2'd2,
        DONE  = 2'd3
    } alu_state_e;

    typedef enum logic [1:0] {
        ITER_SLL = 2'd0,
        ITER_SRL = 2'd1,
        ITER_MUL = 2'd2
    } iter_mode_e;

endpackage

// File: rtl/alu_iter_unit.sv
// One-bit-per-cycle shifter and shift-add multiplier with its down-counter.
// The multiplier part exists only when MULTICYCLE_ALU_MUL_EN is defined.
module alu_iter_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH_DEF,
    parameter int CW    = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  iter_mode_e       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [CW-1:0]    amount,
`ifdef MULTICYCLE_ALU_MUL_EN
    input  logic [WIDTH-1:0] b,
`endif
    output logic             last,
    output logic [WIDTH-1:0] result_next
);

    logic [WIDTH-1:0] data_q, data_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    iter_mode_e       mode_q, mode_d;
    logic [WIDTH-1:0] step;
`ifdef MULTICYCLE_ALU_MUL_EN
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
`endif

    // result_next is the value the datapath holds after the current step,
    // so the top can capture the final answer on the counter's last edge.
    always_comb begin
        data_d      = data_q;
        cnt_d       = cnt_q;
        mode_d      = mode_q;
        step        = data_q;
        result_next = data_q;
`ifdef MULTICYCLE_ALU_MUL_EN
        acc_d       = acc_q;
        mplier_d    = mplier_q;
`endif
        case (mode_q)
            ITER_SLL: begin
                step        = data_q << 1;
                result_next = step;
            end
            ITER_SRL: begin
                step        = data_q >> 1;
                result_next = step;
            end
`ifdef MULTICYCLE_ALU_MUL_EN
            ITER_MUL: begin
                step        = data_q << 1;
                result_next = acc_q + (mplier_q[0] ? data_q : '0);
            end
`endif
            default: begin
                step        = data_q;
                result_next = data_q;
            end
        endcase

        if (start) begin
            data_d = a;
            mode_d = mode;
            cnt_d  = amount;
`ifdef MULTICYCLE_ALU_MUL_EN
            acc_d    = '0;
            mplier_d = b;
            if (mode == ITER_MUL) begin
                cnt_d = CW'(WIDTH);
            end
`endif
        end else if (cnt_q != '0) begin
            data_d = step;
            cnt_d  = cnt_q - CW'(1);
`ifdef MULTICYCLE_ALU_MUL_EN
            acc_d    = result_next;
            mplier_d = mplier_q >> 1;
`endif
        end
    end

    assign last = (cnt_q == CW'(1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q   <= '0;
            cnt_q    <= '0;
            mode_q   <= ITER_SLL;
`ifdef MULTICYCLE_ALU_MUL_EN
            acc_q    <= '0;
            mplier_q <= '0;
`endif
        end else begin
            data_q   <= data_d;
            cnt_q    <= cnt_d;
            mode_q   <= mode_d;
`ifdef MULTICYCLE_ALU_MUL_EN
            acc_q    <= acc_d;
            mplier_q <= mplier_d;
`endif
        end
    end

endmodule

// File: rtl/multicycle_alu.sv
// Handshaked ALU: single-cycle ops, iterative shifts and optional shift-add MUL.
// MUL (opcode 24) is implemented only when MULTICYCLE_ALU_MUL_EN is defined.
module multicycle_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH_DEF,
    parameter int OPW   = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OPW-1:0]   opcode,
    input  logic [WIDTH-1:0] reg_rs1,
    input  logic [WIDTH-1:0] reg_rs2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_out,
    output logic             op_err
);

    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = SHW + 1;

    alu_state_e       state_q, state_d;
    logic [WIDTH-1:0] alu_out_q, alu_out_d;
    logic             op_err_q, op_err_d;
    logic             out_valid_q, out_valid_d;

    logic [31:0]      op_ext;
    logic [SHW-1:0]   shamt;
    logic             is_shift;
    logic [WIDTH-1:0] sc_res;
    logic             sc_err;

    logic             iter_start;
    iter_mode_e       iter_mode;
    logic             iter_last;
    logic [WIDTH-1:0] iter_result_next;

    assign op_ext   = 32'(opcode);
    assign shamt    = reg_rs2[SHW-1:0];
    assign is_shift = (op_ext == OP_SLI) || (op_ext == OP_SRI);

    // Single-cycle result; a zero-amount shift passes rs1 straight through.
    always_comb begin
        sc_res = '0;
        sc_err = 1'b0;
        case (op_ext)
            OP_ADD: sc_res = reg_rs1 + reg_rs2;
            OP_SUB: sc_res = reg_rs1 - reg_rs2;
            OP_AND: sc_res = reg_rs1 & reg_rs2;
            OP_OR:  sc_res = reg_rs1 | reg_rs2;
            OP_XOR: sc_res = reg_rs1 ^ reg_rs2;
            OP_SGE: sc_res = WIDTH'($signed(reg_rs1) >= $signed(reg_rs2));
            OP_SLT: sc_res = WIDTH'($signed(reg_rs1) < $signed(reg_rs2));
            OP_SEQ: sc_res = WIDTH'(reg_rs1 == reg_rs2);
            OP_SLI: sc_res = reg_rs1;
            OP_SRI: sc_res = reg_rs1;
`ifdef MULTICYCLE_ALU_MUL_EN
            OP_MUL: sc_res = '0;
`endif
            default: sc_err = 1'b1;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        alu_out_d   = alu_out_q;
        op_err_d    = op_err_q;
        out_valid_d = out_valid_q;
        iter_start  = 1'b0;
        iter_mode   = (op_ext == OP_SRI) ? ITER_SRL : ITER_SLL;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (is_shift && (shamt != '0)) begin
                        iter_start = 1'b1;
                        state_d    = SHIFT;
`ifdef MULTICYCLE_ALU_MUL_EN
                    end else if (op_ext == OP_MUL) begin
                        iter_start = 1'b1;
                        iter_mode  = ITER_MUL;
                        state_d    = MUL;
`endif
                    end else begin
                        alu_out_d   = sc_res;
                        op_err_d    = sc_err;
                        out_valid_d = 1'b1;
                        state_d     = DONE;
                    end
                end
            end
            SHIFT: begin
                if (iter_last) begin
                    alu_out_d   = iter_result_next;
                    op_err_d    = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
`ifdef MULTICYCLE_ALU_MUL_EN
            MUL: begin
                if (iter_last) begin
                    alu_out_d   = iter_result_next;
                    op_err_d    = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
`endif
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            alu_out_q   <= '0;
            op_err_q    <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            alu_out_q   <= alu_out_d;
            op_err_q    <= op_err_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign alu_out   = alu_out_q;
    assign op_err    = op_err_q;
    assign out_valid = out_valid_q;

    alu_iter_unit #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_iter (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (iter_start),
        .mode        (iter_mode),
        .a           (reg_rs1),
        .amount      ({1'b0, shamt}),
`ifdef MULTICYCLE_ALU_MUL_EN
        .b           (reg_rs2),
`endif
        .last        (iter_last),
        .result_next (iter_result_next)
    );

endmodule

// File: tb/tb_multicycle_alu.sv
// Directed, table-driven bench for multicycle_alu (WIDTH=32); MUL vectors follow
// MULTICYCLE_ALU_MUL_EN.
module tb_multicycle_alu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  opcode;
    logic [31:0] reg_rs1;
    logic [31:0] reg_rs2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] alu_out;
    logic        op_err;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    multicycle_alu #(.WIDTH(32), .OPW(6)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .reg_rs1   (reg_rs1),
        .reg_rs2   (reg_rs2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .alu_out   (alu_out),
        .op_err    (op_err)
    );

    typedef struct {
        string       name;
        logic [5:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_out;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accepts one request, scrambles the inputs, then measures latency and result.
    task automatic run_op(input vec_t v);
        int lat;
        opcode    = v.op;
        reg_rs1   = v.a;
        reg_rs2   = v.b;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        check({v.name, "_in_ready"}, in_ready, 1);
        tick();
        in_valid = 1'b0;
        opcode   = 6'($urandom);
        reg_rs1  = $urandom;
        reg_rs2  = $urandom;
        lat = 1;
        while (!out_valid && lat < 200) begin
            tick();
            lat++;
        end
        check({v.name, "_out_valid"}, out_valid, 1);
        check({v.name, "_alu_out"}, alu_out, v.exp_out);
        check({v.name, "_op_err"}, op_err, v.exp_err);
        check({v.name, "_latency"}, lat, v.exp_lat);
        $display("op=%0d a=0x%08h b=0x%08h -> out=0x%08h err=%0d lat=%0d (%s)",
                 v.op, v.a, v.b, alu_out, op_err, lat, v.name);
        tick();
        check({v.name, "_back_idle"}, in_ready, 1);
        check({v.name, "_valid_drop"}, out_valid, 0);
    endtask

    initial begin
        int pulses;
        vecs.push_back('{"ADD",      6'd1,  32'd1,          32'd2,          32'd3,          1'b0, 1});
        vecs.push_back('{"ADD_WRAP", 6'd1,  32'hFFFFFFFF,   32'd1,          32'd0,          1'b0, 1});
        vecs.push_back('{"SUB",      6'd2,  32'd1,          32'd2,          32'hFFFFFFFF,   1'b0, 1});
        vecs.push_back('{"AND",      6'd3,  32'hF0F0FF00,   32'h0FF00F0F,   32'h00F00F00,   1'b0, 1});
        vecs.push_back('{"OR",       6'd4,  32'hF0F0FF00,   32'h0FF00F0F,   32'hFFF0FF0F,   1'b0, 1});
        vecs.push_back('{"XOR",      6'd5,  32'hF0F0FF00,   32'h0FF00F0F,   32'hFF00F00F,   1'b0, 1});
        vecs.push_back('{"SGE_T",    6'd6,  32'd5,          32'd1,          32'd1,          1'b0, 1});
        vecs.push_back('{"SGE_F",    6'd6,  32'hFFFFFFFF,   32'd1,          32'd0,          1'b0, 1});
        vecs.push_back('{"SLT_T",    6'd7,  32'hFFFFFFFF,   32'd0,          32'd1,          1'b0, 1});
        vecs.push_back('{"SLT_F",    6'd7,  32'd0,          32'hFFFFFFFF,   32'd0,          1'b0, 1});
        vecs.push_back('{"SEQ_T",    6'd10, 32'd5,          32'd5,          32'd1,          1'b0, 1});
        vecs.push_back('{"SEQ_F",    6'd10, 32'd5,          32'd6,          32'd0,          1'b0, 1});
        vecs.push_back('{"SLI_1",    6'd17, 32'd5,          32'd1,          32'hA,          1'b0, 2});
        vecs.push_back('{"SRI_31",   6'd18, 32'h80000000,   32'd31,         32'd1,          1'b0, 32});
        vecs.push_back('{"SLI_32",   6'd17, 32'd5,          32'd32,         32'd5,          1'b0, 1});
        vecs.push_back('{"SRI_4",    6'd18, 32'hF0000000,   32'h24,         32'h0F000000,   1'b0, 5});
        vecs.push_back('{"SLI_31",   6'd17, 32'd1,          32'd31,         32'h80000000,   1'b0, 32});
        vecs.push_back('{"ILL_0",    6'd0,  32'd9,          32'd9,          32'd0,          1'b1, 1});
        vecs.push_back('{"ILL_63",   6'd63, 32'd7,          32'd3,          32'd0,          1'b1, 1});
`ifdef MULTICYCLE_ALU_MUL_EN
        vecs.push_back('{"MUL_A",    6'd24, 32'hFFFFFFFF,   32'd2,          32'hFFFFFFFE,   1'b0, 33});
        vecs.push_back('{"MUL_B",    6'd24, 32'd12345,      32'd678,        32'd8369910,    1'b0, 33});
`else
        vecs.push_back('{"MUL_OFF",  6'd24, 32'hFFFFFFFF,   32'd2,          32'd0,          1'b1, 1});
`endif

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        opcode    = '0;
        reg_rs1   = '0;
        reg_rs2   = '0;
        repeat (3) tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_alu_out", alu_out, 0);
        check("rst_op_err", op_err, 0);
        rst_n = 1'b1;
        tick();
        check("rst_in_ready", in_ready, 1);

        foreach (vecs[i]) run_op(vecs[i]);

        // Back-pressure: result must hold for 5 cycles while in_valid is ignored.
        opcode = 6'd1; reg_rs1 = 32'd7; reg_rs2 = 32'd8;
        in_valid = 1'b1; out_ready = 1'b0;
        tick();
        opcode = 6'd2; reg_rs1 = 32'd100; reg_rs2 = 32'd1;
        for (int c = 0; c < 5; c++) begin
            check("bp_out_valid", out_valid, 1);
            check("bp_alu_out", alu_out, 15);
            check("bp_in_ready", in_ready, 0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        check("bp_release_valid", out_valid, 0);
        check("bp_release_ready", in_ready, 1);
        in_valid = 1'b0;
        tick();
        check("bp_no_reaccept", in_ready, 1);
        $display("back-pressure ADD 7+8 held, released to IDLE");

        // Reset in the middle of a 20-bit shift.
        opcode = 6'd17; reg_rs1 = 32'd3; reg_rs2 = 32'd20;
        in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        check("rs_busy_ready", in_ready, 0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rs_out_valid", out_valid, 0);
        check("rs_alu_out", alu_out, 0);
        check("rs_op_err", op_err, 0);
        check("rs_in_ready", in_ready, 1);
        pulses = 0;
        for (int c = 0; c < 30; c++) begin
            if (out_valid) pulses++;
            tick();
        end
        check("rs_no_pulse", pulses, 0);
        $display("reset mid-SHIFT aborted, %0d stray out_valid cycles", pulses);

        // Reset while a result waits in DONE.
        opcode = 6'd5; reg_rs1 = 32'hFF; reg_rs2 = 32'h0F;
        in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        check("rd_pending", out_valid, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rd_out_valid", out_valid, 0);
        check("rd_alu_out", alu_out, 0);
        check("rd_in_ready", in_ready, 1);
        $display("reset in DONE discarded pending result");

        run_op('{"POST_RST", 6'd18, 32'h100, 32'd8, 32'd1, 1'b0, 9});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_alu.md
MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the operand and result width in bits (legal range 8..64).
REQ-002 Parameter OPW, default 6, SHALL set the opcode width in bits.
REQ-003 Port clk, input, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1, SHALL be the reset: synchronous, active-low.
REQ-005 Port in_valid, input, 1, SHALL mark a valid request (opcode, reg_rs1, reg_rs2).
REQ-006 Port in_ready, output, 1, SHALL indicate that a request can be accepted.
REQ-007 Port opcode, input, OPW, SHALL select the operation.
REQ-008 Ports reg_rs1 and reg_rs2, input, WIDTH each, SHALL carry the source operands.
REQ-009 Port out_valid, output, 1, SHALL mark a valid result.
REQ-010 Port out_ready, input, 1, SHALL indicate that the consumer accepts the result.
REQ-011 Port alu_out, output, WIDTH, SHALL carry the result.
REQ-012 Port op_err, output, 1, SHALL flag an illegal opcode; it is valid only with out_valid.

Function
REQ-013 Opcodes: ADD=1, SUB=2, AND=3, OR=4, XOR=5, SGE=6 (signed), SLT=7 (signed), SEQ=10, SLI=17 (shift left), SRI=18 (logical shift right), MUL=24 (only when configured).
REQ-014 SGE, SLT and SEQ SHALL return 1 or 0, zero-extended to WIDTH; ADD, SUB and MUL SHALL wrap modulo 2^WIDTH and return the low WIDTH bits.
REQ-015 The shift amount SHALL be reg_rs2[$clog2(WIDTH)-1:0]; the upper bits of reg_rs2 SHALL be ignored.
REQ-016 FSM states SHALL be IDLE, SHIFT, MUL and DONE; in_ready SHALL be 1 only in IDLE.
REQ-017 Accept: when in_valid and in_ready are both 1 in IDLE, operands and opcode SHALL be latched.
REQ-018 Single-cycle operations (logic, add, compare, illegal, and shifts by 0) SHALL go IDLE->DONE; out_valid SHALL be 1 in the cycle after accept.
REQ-019 A shift by k>0 SHALL go IDLE->SHIFT, shift 1 bit per cycle, and enter DONE after k cycles, giving a latency of k+1.
REQ-020 MUL SHALL go IDLE->MUL as a shift-add over WIDTH cycles, then DONE, giving a latency of WIDTH+1.
REQ-021 In DONE, alu_out, op_err and out_valid SHALL be held stable until out_ready=1.
REQ-022 Handshake complete (out_valid and out_ready both 1): the FSM SHALL go DONE->IDLE; in_ready SHALL rise in the next cycle, with no same-cycle re-accept.
REQ-023 Illegal opcode: the FSM SHALL go to DONE in 1 cycle with alu_out=0 and op_err=1.
REQ-024 in_valid asserted outside IDLE SHALL be ignored, and the latched operands SHALL remain unchanged.
REQ-025 Input changes after accept SHALL NOT affect the result.

Reset
REQ-026 When rst_n=0 at a rising clk edge: the FSM SHALL go to IDLE, and alu_out=0, op_err=0, out_valid=0, with the counter and operand registers cleared.
REQ-027 In the cycle after reset deasserts, in_ready SHALL be 1.
REQ-028 Reset mid-SHIFT, mid-MUL or in DONE SHALL abort the operation and discard the result, with no out_valid pulse.

Configuration
REQ-029 Macro MULTICYCLE_ALU_MUL_EN defined: the MUL state and opcode 24 SHALL be implemented per REQ-020.
REQ-030 Macro undefined: opcode 24 SHALL be treated as illegal per REQ-023, and no multiplier or MUL state logic SHALL be present.

Structure
REQ-031 Package alu_pkg SHALL hold the opcode localparams, the FSM state typedef and encoding, and the default WIDTH.
REQ-032 Sub-module alu_iter_unit SHALL hold the shift and shift-add datapath and the bit counter, with its MUL part under the macro.
REQ-033 multicycle_alu SHALL hold the FSM, handshake logic, single-cycle ALU and output registers.

Verification
REQ-034 Case ADD: rs1=1, rs2=2, out_ready=1 -> out_valid 1 cycle after accept, alu_out=3, op_err=0.
REQ-035 Case SGE: rs1=5, rs2=1 -> 1; case SEQ: rs1=5, rs2=5 -> 1; case SLT: rs1=0xFFFFFFFF, rs2=0 -> 1 (signed).
REQ-036 Case SLI: rs1=5, rs2=1 -> alu_out=0xA after 2 cycles; case SRI: rs1=0x80000000, rs2=31 -> 1 after 32 cycles; case SLI with rs2=32 -> amount 0, alu_out=rs1 after 1 cycle.
REQ-037 Case back-pressure: out_ready held 0 for 5 cycles after DONE -> alu_out stable, in_ready=0, in_valid ignored; out_ready=1 -> IDLE in the next cycle.
REQ-038 Case MUL with macro: rs1=0xFFFFFFFF, rs2=2 -> 0xFFFFFFFE after 33 cycles; without macro: opcode 24 -> op_err=1, alu_out=0; case opcode 63 -> op_err=1.
REQ-039 Case reset during SHIFT (rs2=20, rst_n=0 at cycle 5) -> no out_valid, outputs 0, in_ready=1 after release.
